// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//
// Two-master Wishbone classic arbiter. Master 0 is the instruction-fetch path
// and master 1 is the load/store path. Both share one memory slave port.
// The granted master's cycle is forwarded to the slave combinationally.
// Ack/err are returned only to the granted master. The grant is held while
// the master keeps cyc high, which gives bus lock across multi-beat cycles.
// Simultaneous requests from IDLE are resolved round-robin.
// A watchdog ends a strobe that has waited TIMEOUT cycles: it returns an
// error to the master and drops cyc/stb to the slave for that cycle.
//
// Ports
//   wb_clk, wb_rst_n               clock, asynchronous active-low reset
//   m0_* / m1_*                    master-side Wishbone signals (fetch / data)
//   s_*                            slave-side Wishbone signals
//   grant_o[1:0]                   one-hot grant (bit0 = m0, bit1 = m1), 00 = idle
//   timeout_o                      one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   localparam int SEL_W  = DATA_W / 8
) (
   input  logic              wb_clk,
   input  logic              wb_rst_n,
   // master 0 (fetch)
   input  logic              m0_cyc_i,
   input  logic              m0_stb_i,
   input  logic              m0_we_i,
   input  logic [ADDR_W-1:0] m0_adr_i,
   input  logic [DATA_W-1:0] m0_dat_i,
   input  logic [SEL_W-1:0]  m0_sel_i,
   output logic [DATA_W-1:0] m0_dat_o,
   output logic              m0_ack_o,
   output logic              m0_err_o,
   // master 1 (data)
   input  logic              m1_cyc_i,
   input  logic              m1_stb_i,
   input  logic              m1_we_i,
   input  logic [ADDR_W-1:0] m1_adr_i,
   input  logic [DATA_W-1:0] m1_dat_i,
   input  logic [SEL_W-1:0]  m1_sel_i,
   output logic [DATA_W-1:0] m1_dat_o,
   output logic              m1_ack_o,
   output logic              m1_err_o,
   // slave
   output logic              s_cyc_o,
   output logic              s_stb_o,
   output logic              s_we_o,
   output logic [ADDR_W-1:0] s_adr_o,
   output logic [DATA_W-1:0] s_dat_o,
   output logic [SEL_W-1:0]  s_sel_o,
   input  logic [DATA_W-1:0] s_dat_i,
   input  logic              s_ack_i,
   input  logic              s_err_i,
   // status
   output logic [1:0]        grant_o,
   output logic              timeout_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t      state, next_state;
   logic        last;        // master granted most recently (1 = m1)
   logic [15:0] wait_cnt;

   logic        mux_cyc;
   logic        mux_stb;
   logic        timeout;

   // ---------------------------------------------------------------------------
   // State, round-robin history and watchdog counter
   // ---------------------------------------------------------------------------
   // NOTE: all registers use non-blocking assignments so every flop samples
   // the values from before the edge, regardless of block ordering.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= next_state;
         if (next_state == GNT0) last <= 1'b0;
         else if (next_state == GNT1) last <= 1'b1;
      end
   end

   // s_stb_o is already forced low when the watchdog fires, so the
   // !s_stb_o term also clears the counter after a timeout.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         wait_cnt <= '0;
      end else if ((next_state != state) || s_ack_i || s_err_i || !s_stb_o) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis would infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) next_state = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        next_state = GNT0;
            else if (m1_cyc_i)        next_state = GNT1;
         end
         GNT0: begin
            if (!m0_cyc_i) next_state = m1_cyc_i ? GNT1 : IDLE;
         end
         GNT1: begin
            if (!m1_cyc_i) next_state = m0_cyc_i ? GNT0 : IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Slave-side multiplexer
   // ---------------------------------------------------------------------------
   always_comb begin
      mux_cyc = 1'b0;
      mux_stb = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      unique case (state)
         GNT0: begin
            mux_cyc = m0_cyc_i;
            mux_stb = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
         end
         GNT1: begin
            mux_cyc = m1_cyc_i;
            mux_stb = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
         end
         default: ;
      endcase
   end

   // A slave response in the same cycle takes priority over the watchdog.
   assign timeout   = (TIMEOUT != 0) && mux_stb && (wait_cnt == TMO)
                      && !s_ack_i && !s_err_i;
   assign timeout_o = timeout;

   assign s_cyc_o = mux_cyc & ~timeout;
   assign s_stb_o = mux_stb & ~timeout;

   // ---------------------------------------------------------------------------
   // Master-side returns
   // ---------------------------------------------------------------------------
   assign grant_o  = {state == GNT1, state == GNT0};

   assign m0_ack_o = grant_o[0] & s_ack_i;
   assign m1_ack_o = grant_o[1] & s_ack_i;
   assign m0_err_o = grant_o[0] & (s_err_i | timeout);
   assign m1_err_o = grant_o[1] & (s_err_i | timeout);

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed bench for wb_arbiter (TIMEOUT = 4). A vector table covers
// arbitration, handover, routing and lock. Hand-written sequences cover reset,
// a waited read, the watchdog and reset in the middle of a transfer.
// Inputs are driven on the falling edge and outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int SEL_W  = DATA_W / 8;

   localparam logic [31:0] M0_ADR = 32'h0000_0100;
   localparam logic [31:0] M1_ADR = 32'h0000_2000;

   logic              wb_clk = 1'b0;
   logic              wb_rst_n;
   logic              m0_cyc, m0_stb, m0_we;
   logic [ADDR_W-1:0] m0_adr;
   logic [DATA_W-1:0] m0_wdat, m0_rdat;
   logic [SEL_W-1:0]  m0_sel;
   logic              m0_ack, m0_err;
   logic              m1_cyc, m1_stb, m1_we;
   logic [ADDR_W-1:0] m1_adr;
   logic [DATA_W-1:0] m1_wdat, m1_rdat;
   logic [SEL_W-1:0]  m1_sel;
   logic              m1_ack, m1_err;
   logic              s_cyc, s_stb, s_we;
   logic [ADDR_W-1:0] s_adr;
   logic [DATA_W-1:0] s_wdat, s_rdat;
   logic [SEL_W-1:0]  s_sel;
   logic              s_ack, s_err;
   logic [1:0]        grant;
   logic              timeout;

   int checks = 0;
   int errors = 0;

   always #5 wb_clk = ~wb_clk;

   wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
      .wb_clk    (wb_clk),
      .wb_rst_n  (wb_rst_n),
      .m0_cyc_i  (m0_cyc),
      .m0_stb_i  (m0_stb),
      .m0_we_i   (m0_we),
      .m0_adr_i  (m0_adr),
      .m0_dat_i  (m0_wdat),
      .m0_sel_i  (m0_sel),
      .m0_dat_o  (m0_rdat),
      .m0_ack_o  (m0_ack),
      .m0_err_o  (m0_err),
      .m1_cyc_i  (m1_cyc),
      .m1_stb_i  (m1_stb),
      .m1_we_i   (m1_we),
      .m1_adr_i  (m1_adr),
      .m1_dat_i  (m1_wdat),
      .m1_sel_i  (m1_sel),
      .m1_dat_o  (m1_rdat),
      .m1_ack_o  (m1_ack),
      .m1_err_o  (m1_err),
      .s_cyc_o   (s_cyc),
      .s_stb_o   (s_stb),
      .s_we_o    (s_we),
      .s_adr_o   (s_adr),
      .s_dat_o   (s_wdat),
      .s_sel_o   (s_sel),
      .s_dat_i   (s_rdat),
      .s_ack_i   (s_ack),
      .s_err_i   (s_err),
      .grant_o   (grant),
      .timeout_o (timeout)
   );

   typedef struct {
      // inputs
      logic        c0, s0, c1, s1, ack, err;
      // expected outputs
      logic [1:0]  gnt;
      logic        scyc, sstb;
      logic [31:0] sadr;
      logic        a0, e0, a1, e1;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c0, s0, c1, s1, ack, err);
      m0_cyc = c0;
      m0_stb = s0;
      m1_cyc = c1;
      m1_stb = s1;
      s_ack  = ack;
      s_err  = err;
   endtask

   // Advance to the falling edge, apply inputs, let the combinational paths settle.
   task automatic cycle(input logic c0, s0, c1, s1, ack, err);
      @(negedge wb_clk);
      drive(c0, s0, c1, s1, ack, err);
      #1;
   endtask

   vec_t vecs [15];

   initial begin
      // m0 never wins a tie on the first table entry: the reset sequence
      // leaves m0 as the last-granted master.
      //           c0 s0 c1 s1 ak er  gnt    scyc sstb sadr    a0 e0 a1 e1
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0,   0, 0, 0, 0};
      vecs[1]  = '{1, 1, 1, 1, 0, 0, 2'b00, 0, 0, 32'h0,   0, 0, 0, 0}; // tie -> m1
      vecs[2]  = '{1, 1, 1, 1, 0, 0, 2'b10, 1, 1, M1_ADR,  0, 0, 0, 0};
      vecs[3]  = '{1, 1, 1, 1, 1, 0, 2'b10, 1, 1, M1_ADR,  0, 0, 1, 0}; // ack to m1 only
      vecs[4]  = '{1, 1, 0, 0, 0, 0, 2'b10, 0, 0, M1_ADR,  0, 0, 0, 0}; // m1 releases
      vecs[5]  = '{1, 1, 1, 1, 1, 0, 2'b01, 1, 1, M0_ADR,  1, 0, 0, 0}; // no idle gap
      vecs[6]  = '{0, 0, 1, 1, 0, 0, 2'b01, 0, 0, M0_ADR,  0, 0, 0, 0}; // m0 releases
      vecs[7]  = '{1, 1, 1, 1, 0, 1, 2'b10, 1, 1, M1_ADR,  0, 0, 0, 1}; // err to m1 only
      vecs[8]  = '{0, 0, 0, 0, 0, 0, 2'b10, 0, 0, M1_ADR,  0, 0, 0, 0};
      vecs[9]  = '{1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0,   0, 0, 0, 0}; // single req
      vecs[10] = '{1, 1, 1, 1, 1, 0, 2'b01, 1, 1, M0_ADR,  1, 0, 0, 0};
      vecs[11] = '{1, 0, 1, 1, 0, 0, 2'b01, 1, 0, M0_ADR,  0, 0, 0, 0}; // lock, stb low
      vecs[12] = '{1, 1, 1, 1, 0, 0, 2'b01, 1, 1, M0_ADR,  0, 0, 0, 0}; // second beat
      vecs[13] = '{0, 0, 0, 0, 0, 0, 2'b01, 0, 0, M0_ADR,  0, 0, 0, 0};
      vecs[14] = '{0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0,   0, 0, 0, 0};

      m0_we   = 1'b0;
      m0_adr  = M0_ADR;
      m0_wdat = 32'hAAAA_0000;
      m0_sel  = 4'hF;
      m1_we   = 1'b0;
      m1_adr  = M1_ADR;
      m1_wdat = 32'h5555_1111;
      m1_sel  = 4'h3;
      s_rdat  = 32'h0;

      // ---- Reset with both masters requesting (ack high must not leak) ----
      wb_rst_n = 1'b0;
      drive(1, 1, 1, 1, 1, 0);
      #2;
      check("rst grant",   32'(grant),   32'h0);
      check("rst s_cyc",   32'(s_cyc),   32'h0);
      check("rst s_stb",   32'(s_stb),   32'h0);
      check("rst s_adr",   s_adr,        32'h0);
      check("rst m0_ack",  32'(m0_ack),  32'h0);
      check("rst m1_ack",  32'(m1_ack),  32'h0);
      check("rst timeout", 32'(timeout), 32'h0);
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      s_ack    = 1'b0;
      @(negedge wb_clk);
      #1;
      check("rel grant", 32'(grant), 32'h1);
      check("rel s_adr", s_adr,      M0_ADR);
      cycle(0, 0, 0, 0, 0, 0);           // release -> IDLE at next edge

      // ---- Table-driven vectors ----
      for (int i = 0; i < 15; i++) begin
         cycle(vecs[i].c0, vecs[i].s0, vecs[i].c1, vecs[i].s1, vecs[i].ack, vecs[i].err);
         check($sformatf("v%0d grant", i),  32'(grant),  32'(vecs[i].gnt));
         check($sformatf("v%0d s_cyc", i),  32'(s_cyc),  32'(vecs[i].scyc));
         check($sformatf("v%0d s_stb", i),  32'(s_stb),  32'(vecs[i].sstb));
         check($sformatf("v%0d s_adr", i),  s_adr,       vecs[i].sadr);
         check($sformatf("v%0d m0_ack", i), 32'(m0_ack), 32'(vecs[i].a0));
         check($sformatf("v%0d m0_err", i), 32'(m0_err), 32'(vecs[i].e0));
         check($sformatf("v%0d m1_ack", i), 32'(m1_ack), 32'(vecs[i].a1));
         check($sformatf("v%0d m1_err", i), 32'(m1_err), 32'(vecs[i].e1));
      end

      // ---- Single m1 read, three wait states ----
      cycle(0, 0, 1, 1, 0, 0);
      check("rd idle grant", 32'(grant), 32'h0);
      for (int w = 0; w < 3; w++) begin
         cycle(0, 0, 1, 1, 0, 0);
         check($sformatf("rd w%0d grant", w),  32'(grant),  32'h2);
         check($sformatf("rd w%0d s_adr", w),  s_adr,       M1_ADR);
         check($sformatf("rd w%0d m1_ack", w), 32'(m1_ack), 32'h0);
         check($sformatf("rd w%0d m0_ack", w), 32'(m0_ack), 32'h0);
      end
      check("rd s_sel", 32'(s_sel), 32'h3);
      check("rd s_dat", s_wdat,     32'h5555_1111);
      s_rdat = 32'hDEAD_BEEF;
      cycle(0, 0, 1, 1, 1, 0);
      check("rd m1_ack",  32'(m1_ack), 32'h1);
      check("rd m1_dat",  m1_rdat,     32'hDEAD_BEEF);
      check("rd m0_dat",  m0_rdat,     32'hDEAD_BEEF);
      check("rd m0_ack",  32'(m0_ack), 32'h0);
      cycle(0, 0, 0, 0, 0, 0);
      check("rd ack gone", 32'(m1_ack), 32'h0);
      cycle(0, 0, 0, 0, 0, 0);
      check("rd back idle", 32'(grant), 32'h0);

      // ---- Watchdog: no ack, fires after stb has been high 4 cycles ----
      cycle(1, 1, 0, 0, 0, 0);
      for (int w = 0; w < 4; w++) begin
         cycle(1, 1, 0, 0, 0, 0);
         check($sformatf("wd w%0d timeout", w), 32'(timeout), 32'h0);
         check($sformatf("wd w%0d s_stb", w),   32'(s_stb),   32'h1);
         check($sformatf("wd w%0d m0_err", w),  32'(m0_err),  32'h0);
      end
      cycle(1, 1, 0, 0, 0, 0);
      check("wd fire timeout", 32'(timeout), 32'h1);
      check("wd fire m0_err",  32'(m0_err),  32'h1);
      check("wd fire s_stb",   32'(s_stb),   32'h0);
      check("wd fire s_cyc",   32'(s_cyc),   32'h0);
      check("wd fire m1_err",  32'(m1_err),  32'h0);
      check("wd fire grant",   32'(grant),   32'h1);
      // Counter restarts; this time the ack lands in the cycle it would fire.
      for (int w = 0; w < 4; w++) begin
         cycle(1, 1, 0, 0, 0, 0);
         check($sformatf("wd2 w%0d timeout", w), 32'(timeout), 32'h0);
         check($sformatf("wd2 w%0d s_stb", w),   32'(s_stb),   32'h1);
      end
      cycle(1, 1, 0, 0, 1, 0);
      check("wd ack m0_ack",  32'(m0_ack),  32'h1);
      check("wd ack m0_err",  32'(m0_err),  32'h0);
      check("wd ack timeout", 32'(timeout), 32'h0);
      check("wd ack s_stb",   32'(s_stb),   32'h1);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      check("wd back idle", 32'(grant), 32'h0);

      // ---- Reset in the middle of an m1 transfer ----
      cycle(0, 0, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 0, 0);
      check("mid grant", 32'(grant), 32'h2);
      check("mid s_cyc", 32'(s_cyc), 32'h1);
      s_ack    = 1'b1;
      wb_rst_n = 1'b0;
      #1;
      check("mid rst s_cyc",  32'(s_cyc),  32'h0);
      check("mid rst grant",  32'(grant),  32'h0);
      check("mid rst m1_ack", 32'(m1_ack), 32'h0);
      drive(1, 1, 1, 1, 0, 0);
      @(negedge wb_clk);
      wb_rst_n = 1'b1;
      @(negedge wb_clk);
      #1;
      check("post rst tie grant", 32'(grant), 32'h1);
      check("post rst s_adr",     s_adr,      M0_ADR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
